// File: rtl/recebe_hamming_serial_pkg.sv
// -----------------------------------------------------------------------------
// recebe_hamming_serial_pkg
//   Shared definitions for the serial Hamming(15,11) receiver:
//   - codeword / data widths of the Hamming(15,11) code,
//   - bit indices of the parity positions inside the 15-bit codeword,
//   - FSM state encoding of the receiver.
//
//   Codeword bit ordering: bit 14 holds code position 1, bit 0 holds code
//   position 15. Parity positions 1/2/4/8 are therefore bits 14/13/11/7.
// -----------------------------------------------------------------------------
package recebe_hamming_serial_pkg;

  localparam int LARGURA_CW    = 15;
  localparam int LARGURA_DADOS = 11;
  localparam int N_PARIDADE    = LARGURA_CW - LARGURA_DADOS;

  // Codeword bit index of each parity position (position p lives at bit 15-p).
  localparam int POS_P1 = 14;
  localparam int POS_P2 = 13;
  localparam int POS_P4 = 11;
  localparam int POS_P8 = 7;

  typedef enum logic {
    OCIOSO = 1'b0,  // waiting for a frame_start bit
    RECEBE = 1'b1   // collecting the remaining bits of a frame
  } estado_t;

  // True when codeword bit index 'idx' carries a parity bit rather than data.
  function automatic logic eh_paridade(input int idx);
    return (idx == POS_P1) || (idx == POS_P2) || (idx == POS_P4) || (idx == POS_P8);
  endfunction

endpackage : recebe_hamming_serial_pkg

// File: rtl/recebe_hamming_serial_registro_saida_hs.sv
// -----------------------------------------------------------------------------
// registro_saida_hs
//   One-entry valid/ready output buffer for completed codewords.
//   A new word loads when the buffer is empty, or when it is full and the
//   held word is consumed on the same cycle. Otherwise the new word is
//   dropped, the held word is kept and erro_overrun pulses for one cycle.
//
// Ports
//   clk            in   rising-edge clock
//   rst            in   synchronous, active-high reset (empties the buffer)
//   palavra_in     in   completed codeword from the assembler
//   palavra_valid  in   palavra_in is complete this cycle (1-cycle strobe)
//   cw_ready       in   consumer accepts the word when cw_valid && cw_ready
//   codeword       out  held codeword (stable while cw_valid && !cw_ready)
//   cw_valid       out  codeword holds an unconsumed word
//   erro_overrun   out  1-cycle pulse: a completed word was dropped
// -----------------------------------------------------------------------------
module registro_saida_hs
  import recebe_hamming_serial_pkg::*;
#(
  parameter int LARGURA = LARGURA_CW
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [LARGURA-1:0] palavra_in,
  input  logic               palavra_valid,
  input  logic               cw_ready,
  output logic [LARGURA-1:0] codeword,
  output logic               cw_valid,
  output logic               erro_overrun
);

  logic [LARGURA-1:0] codeword_q, codeword_d;
  logic               valid_q,    valid_d;
  logic               overrun_q,  overrun_d;
  logic               carrega;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    codeword_d = codeword_q;
    valid_d    = valid_q;
    overrun_d  = 1'b0;
    // Slot is free if empty, or if the held word leaves this very cycle.
    carrega    = palavra_valid && (!valid_q || cw_ready);

    if (carrega) begin
      codeword_d = palavra_in;
      valid_d    = 1'b1;
    end else begin
      if (valid_q && cw_ready) begin
        valid_d = 1'b0;
      end
      if (palavra_valid) begin
        overrun_d = 1'b1;
      end
    end
  end

  // NOTE: state registers use non-blocking assignments only, so every flop
  // samples the values computed before this edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      codeword_q <= '0;
      valid_q    <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      codeword_q <= codeword_d;
      valid_q    <= valid_d;
      overrun_q  <= overrun_d;
    end
  end

  assign codeword     = codeword_q;
  assign cw_valid     = valid_q;
  assign erro_overrun = overrun_q;

endmodule : registro_saida_hs

// File: rtl/recebe_hamming_serial.sv
// -----------------------------------------------------------------------------
// recebe_hamming_serial
//   Serial receiver feeding the Hamming(15,11) corrector. Assembles a 15-bit
//   codeword MSB-first from a framed bit stream (the first bit of a frame ends
//   up in codeword[14], i.e. code position 1) and hands it to a one-entry
//   valid/ready output register.
//
// Ports
//   clk           in   rising-edge clock
//   rst           in   synchronous, active-high reset
//   bit_in        in   serial data bit
//   bit_valid     in   bit_in is valid this cycle
//   frame_start   in   qualified by bit_valid: this bit is code position 1
//   codeword      out  assembled codeword (corrector input 'entrada')
//   cw_valid      out  codeword holds an unconsumed word
//   cw_ready      in   consumer accepts the word when cw_valid && cw_ready
//   erro_quadro   out  1-cycle pulse: frame_start arrived mid-frame
//   erro_timeout  out  1-cycle pulse: frame abandoned after TIMEOUT idle cycles
//   erro_overrun  out  1-cycle pulse: completed word dropped, output full
//
// Parameters
//   LARGURA   codeword width (15 for the Hamming(15,11) corrector)
//   TIMEOUT   max idle cycles between accepted bits inside a frame (>= 2)
// -----------------------------------------------------------------------------
module recebe_hamming_serial
  import recebe_hamming_serial_pkg::*;
#(
  parameter int LARGURA = LARGURA_CW,
  parameter int TIMEOUT = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               bit_in,
  input  logic               bit_valid,
  input  logic               frame_start,
  output logic [LARGURA-1:0] codeword,
  output logic               cw_valid,
  input  logic               cw_ready,
  output logic               erro_quadro,
  output logic               erro_timeout,
  output logic               erro_overrun
);

  localparam int CNT_W = $clog2(LARGURA);
  localparam int TMO_W = $clog2(TIMEOUT + 1);

  localparam logic [CNT_W-1:0] CNT_ULTIMO = CNT_W'(LARGURA - 1);
  localparam logic [TMO_W-1:0] TMO_ULTIMO = TMO_W'(TIMEOUT - 1);

  estado_t            estado_q,  estado_d;
  // Only the first LARGURA-1 bits of a frame are ever stored: the last bit
  // is merged straight from bit_in into the completed word.
  logic [LARGURA-2:0] sr_q,      sr_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [TMO_W-1:0]   tmo_q,     tmo_d;
  logic               quadro_q,  quadro_d;
  logic               timeout_q, timeout_d;

  logic               palavra_valid;
  logic [LARGURA-1:0] palavra;

  // ---------------------------------------------------------------------------
  // Next-state logic: FSM, shift register, bit and idle counters
  // ---------------------------------------------------------------------------
  always_comb begin
    estado_d      = estado_q;
    sr_d          = sr_q;
    cnt_d         = cnt_q;
    tmo_d         = tmo_q;
    quadro_d      = 1'b0;
    timeout_d     = 1'b0;
    palavra_valid = 1'b0;
    palavra       = {sr_q, bit_in};

    unique case (estado_q)
      OCIOSO: begin
        // Bits outside a frame are ignored without flagging anything.
        if (bit_valid && frame_start) begin
          sr_d     = {{(LARGURA-2){1'b0}}, bit_in};
          cnt_d    = CNT_W'(1);
          tmo_d    = '0;
          estado_d = RECEBE;
        end
      end

      RECEBE: begin
        if (bit_valid) begin
          tmo_d = '0;
          if (frame_start) begin
            // Restart takes priority over completion: the partial word is
            // dropped and this bit becomes position 1 of a new frame.
            quadro_d = 1'b1;
            sr_d     = {{(LARGURA-2){1'b0}}, bit_in};
            cnt_d    = CNT_W'(1);
          end else if (cnt_q == CNT_ULTIMO) begin
            palavra_valid = 1'b1;
            sr_d          = '0;
            cnt_d         = '0;
            estado_d      = OCIOSO;
          end else begin
            sr_d  = {sr_q[LARGURA-3:0], bit_in};
            cnt_d = cnt_q + CNT_W'(1);
          end
        end else if (tmo_q == TMO_ULTIMO) begin
          // This is the TIMEOUT-th consecutive idle cycle: abandon the frame.
          timeout_d = 1'b1;
          sr_d      = '0;
          cnt_d     = '0;
          tmo_d     = '0;
          estado_d  = OCIOSO;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end

      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q  <= OCIOSO;
      sr_q      <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      quadro_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      tmo_q     <= tmo_d;
      quadro_q  <= quadro_d;
      timeout_q <= timeout_d;
    end
  end

  assign erro_quadro  = quadro_q;
  assign erro_timeout = timeout_q;

  // ---------------------------------------------------------------------------
  // One-entry output buffer; its register gives the 1-cycle output latency.
  // ---------------------------------------------------------------------------
  registro_saida_hs #(
    .LARGURA (LARGURA)
  ) u_registro_saida (
    .clk           (clk),
    .rst           (rst),
    .palavra_in    (palavra),
    .palavra_valid (palavra_valid),
    .cw_ready      (cw_ready),
    .codeword      (codeword),
    .cw_valid      (cw_valid),
    .erro_overrun  (erro_overrun)
  );

endmodule : recebe_hamming_serial

// File: tb/tb_recebe_hamming_serial.sv
// -----------------------------------------------------------------------------
// tb_recebe_hamming_serial
//   Directed bench for recebe_hamming_serial. Inputs change and outputs are
//   sampled 1 time unit after each rising edge; error pulses are tallied on
//   every cycle so each scenario can count how many it saw.
// -----------------------------------------------------------------------------
module tb_recebe_hamming_serial;
  import recebe_hamming_serial_pkg::*;

  localparam int LARGURA = 15;
  localparam int TIMEOUT = 64;

  logic               clk = 1'b0;
  logic               rst;
  logic               bit_in;
  logic               bit_valid;
  logic               frame_start;
  logic [LARGURA-1:0] codeword;
  logic               cw_valid;
  logic               cw_ready;
  logic               erro_quadro;
  logic               erro_timeout;
  logic               erro_overrun;

  int n_checks = 0;
  int n_pass   = 0;
  int n_quadro  = 0;
  int n_timeout = 0;
  int n_overrun = 0;

  recebe_hamming_serial #(
    .LARGURA (LARGURA),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bit_in       (bit_in),
    .bit_valid    (bit_valid),
    .frame_start  (frame_start),
    .codeword     (codeword),
    .cw_valid     (cw_valid),
    .cw_ready     (cw_ready),
    .erro_quadro  (erro_quadro),
    .erro_timeout (erro_timeout),
    .erro_overrun (erro_overrun)
  );

  always #5 clk = ~clk;

  // Reference Hamming(15,11) corrector: returns the corrected data bits,
  // position-3 data bit first.
  function automatic logic [10:0] hamming_dados(input logic [14:0] cw);
    logic [14:0] c;
    logic [10:0] d;
    int          s;
    int          k;
    s = 0;
    for (int p = 1; p <= 15; p++) begin
      if (cw[15-p]) s = s ^ p;
    end
    c = cw;
    if (s != 0) c[15-s] = ~c[15-s];
    d = '0;
    k = 10;
    for (int i = 14; i >= 0; i--) begin
      if (!eh_paridade(i)) begin
        d[k] = c[i];
        k--;
      end
    end
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    n_quadro  += int'(erro_quadro);
    n_timeout += int'(erro_timeout);
    n_overrun += int'(erro_overrun);
  endtask

  task automatic clear_pulses();
    n_quadro  = 0;
    n_timeout = 0;
    n_overrun = 0;
  endtask

  // Send bits hi..lo of w, one per cycle; frame_start on the first if start.
  task automatic send_bits(input logic [14:0] w, input int hi, input int lo, input bit start);
    for (int i = hi; i >= lo; i--) begin
      bit_in      = w[i];
      bit_valid   = 1'b1;
      frame_start = start && (i == hi);
      tick();
    end
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    bit_in      = 1'b0;
  endtask

  task automatic send_frame(input logic [14:0] w);
    send_bits(w, 14, 0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    n_checks++;
    if ({codeword, cw_valid, erro_quadro, erro_timeout, erro_overrun} !== 19'h0)
      $display("FAIL reset_state: got cw=%h v=%b q=%b t=%b o=%b required all 0",
               codeword, cw_valid, erro_quadro, erro_timeout, erro_overrun);
    else n_pass++;
    rst = 1'b0;
    idle(1);

    // Park a word in the output register, then reset in the middle of a frame.
    cw_ready = 1'b0;
    send_frame(15'h1234);
    send_bits(15'h7FFF, 14, 8, 1'b1);
    clear_pulses();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    n_checks++;
    if ({codeword, cw_valid} !== 16'h0)
      $display("FAIL reset_midframe: got cw=%h v=%b required cw=0000 v=0", codeword, cw_valid);
    else n_pass++;
    n_checks++;
    if (n_quadro + n_timeout + n_overrun != 0)
      $display("FAIL reset_no_pulses: got %0d pulses required 0", n_quadro + n_timeout + n_overrun);
    else n_pass++;

    // Remaining bits of the interrupted frame must not complete anything.
    send_bits(15'h7FFF, 7, 0, 1'b0);
    n_checks++;
    if (cw_valid !== 1'b0)
      $display("FAIL reset_stale_bits: got v=%b required v=0", cw_valid);
    else n_pass++;

    cw_ready = 1'b1;
    send_frame(15'h5555);
    n_checks++;
    if (cw_valid !== 1'b1 || codeword !== 15'h5555)
      $display("FAIL reset_next_frame: got v=%b cw=%h required v=1 cw=5555", cw_valid, codeword);
    else n_pass++;
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    cw_ready = 1'b1;
    clear_pulses();
    send_frame(15'h7FFF);
    n_checks++;
    if (cw_valid !== 1'b1 || codeword !== 15'h7FFF)
      $display("FAIL b2b_first: got v=%b cw=%h required v=1 cw=7fff", cw_valid, codeword);
    else n_pass++;

    // First bit of the next frame immediately; the held word is consumed.
    send_bits(15'h0000, 14, 14, 1'b1);
    n_checks++;
    if (cw_valid !== 1'b0)
      $display("FAIL b2b_handshake: got v=%b required v=0", cw_valid);
    else n_pass++;
    send_bits(15'h0000, 13, 0, 1'b0);
    n_checks++;
    if (cw_valid !== 1'b1 || codeword !== 15'h0000)
      $display("FAIL b2b_second: got v=%b cw=%h required v=1 cw=0000", cw_valid, codeword);
    else n_pass++;
    n_checks++;
    if (n_quadro + n_timeout + n_overrun != 0)
      $display("FAIL b2b_no_errors: got %0d pulses required 0", n_quadro + n_timeout + n_overrun);
    else n_pass++;
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_msb_first();
    cw_ready = 1'b1;
    send_frame(15'b100_0000_0000_0000);
    n_checks++;
    if (cw_valid !== 1'b1 || codeword !== 15'h4000)
      $display("FAIL msb_first_cw: got v=%b cw=%h required v=1 cw=4000", cw_valid, codeword);
    else n_pass++;
    n_checks++;
    if (hamming_dados(codeword) !== 11'h000)
      $display("FAIL msb_first_saida: got %h required 000", hamming_dados(codeword));
    else n_pass++;
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_framing();
    cw_ready = 1'b1;
    clear_pulses();
    send_bits(15'h7FFF, 14, 8, 1'b1);
    send_frame(15'h2AAA);
    n_checks++;
    if (n_quadro != 1)
      $display("FAIL quadro_count: got %0d pulses required 1", n_quadro);
    else n_pass++;
    n_checks++;
    if (cw_valid !== 1'b1 || codeword !== 15'h2AAA)
      $display("FAIL quadro_next_cw: got v=%b cw=%h required v=1 cw=2aaa", cw_valid, codeword);
    else n_pass++;
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    cw_ready = 1'b1;
    idle(2);
    clear_pulses();
    send_bits(15'h5A5B, 14, 10, 1'b1);
    idle(TIMEOUT);
    n_checks++;
    if (n_timeout != 1)
      $display("FAIL timeout_count: got %0d pulses required 1", n_timeout);
    else n_pass++;
    // Back in OCIOSO: the rest of the abandoned frame is ignored silently.
    send_bits(15'h5A5B, 9, 0, 1'b0);
    n_checks++;
    if (cw_valid !== 1'b0 || n_quadro != 0)
      $display("FAIL timeout_idle_state: got v=%b quadro=%0d required v=0 quadro=0",
               cw_valid, n_quadro);
    else n_pass++;

    clear_pulses();
    send_bits(15'h5A5B, 14, 10, 1'b1);
    idle(TIMEOUT - 1);
    send_bits(15'h5A5B, 9, 0, 1'b0);
    n_checks++;
    if (n_timeout != 0 || cw_valid !== 1'b1 || codeword !== 15'h5A5B)
      $display("FAIL timeout_edge: got t=%0d v=%b cw=%h required t=0 v=1 cw=5a5b",
               n_timeout, cw_valid, codeword);
    else n_pass++;
    idle(2);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_overrun();
    int instavel;
    cw_ready = 1'b0;
    clear_pulses();
    send_frame(15'h1357);
    n_checks++;
    if (cw_valid !== 1'b1 || codeword !== 15'h1357)
      $display("FAIL overrun_first: got v=%b cw=%h required v=1 cw=1357", cw_valid, codeword);
    else n_pass++;

    instavel = 0;
    for (int i = 14; i >= 0; i--) begin
      bit_in      = 15'h7531 >> i;
      bit_valid   = 1'b1;
      frame_start = (i == 14);
      tick();
      if (cw_valid !== 1'b1 || codeword !== 15'h1357) instavel++;
    end
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    n_checks++;
    if (instavel != 0)
      $display("FAIL overrun_stable: got %0d unstable cycles required 0", instavel);
    else n_pass++;
    n_checks++;
    if (n_overrun != 1)
      $display("FAIL overrun_count: got %0d pulses required 1", n_overrun);
    else n_pass++;

    cw_ready = 1'b1;
    tick();
    n_checks++;
    if (cw_valid !== 1'b0)
      $display("FAIL overrun_drain: got v=%b required v=0", cw_valid);
    else n_pass++;
    idle(3);
    n_checks++;
    if (cw_valid !== 1'b0 || n_overrun != 1)
      $display("FAIL overrun_single: got v=%b overrun=%0d required v=0 overrun=1",
               cw_valid, n_overrun);
    else n_pass++;
  endtask

  initial begin
    rst         = 1'b1;
    bit_in      = 1'b0;
    bit_valid   = 1'b0;
    frame_start = 1'b0;
    cw_ready    = 1'b1;
    test_reset();
    test_back_to_back();
    test_msb_first();
    test_framing();
    test_timeout();
    test_overrun();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_recebe_hamming_serial
